// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if
//   Handshake and payload bundle between decode, the ALU issue stage and the
//   execute stage.
//   id_*  : decode -> stage (id_ready flows back)
//   ex_*  : stage -> execute (ex_ready flows back)
//   Modports:
//     master : the surrounding pipeline (drives id_* payload and ex_ready)
//     slave  : the issue stage itself
interface alu_issue_stage_if;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;

  logic        ex_valid;
  logic        ex_ready;
  logic [2:0]  ex_alu_op;
  logic [31:0] ex_alu_a;
  logic [31:0] ex_alu_b;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_dest;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_branch;
  logic        ex_illegal;

  modport master (
    output id_valid, id_instr, id_rs_data, id_rt_data, ex_ready,
    input  id_ready, ex_valid, ex_alu_op, ex_alu_a, ex_alu_b, ex_store_data,
           ex_dest, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal
  );

  modport slave (
    input  id_valid, id_instr, id_rs_data, id_rt_data, ex_ready,
    output id_ready, ex_valid, ex_alu_op, ex_alu_a, ex_alu_b, ex_store_data,
           ex_dest, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   ID/EX register feeding the ALU. Decodes a MIPS instruction into a 3-bit
//   ALU opcode, selects/extends the operands and registers everything behind
//   a valid/ready handshake. Also counts issued instructions and stall cycles.
//   Ports:
//     clk, reset   : rising-edge clock, async active-high reset
//     flush        : sync kill of stage contents; blocks loading this cycle
//     bus          : alu_issue_stage_if.slave (id_* in, ex_* out)
//     issue_count  : instructions accepted (wraps)
//     stall_count  : cycles with ex_valid && !ex_ready, flush excluded (wraps)
module alu_issue_stage #(
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  alu_issue_stage_if.slave      bus,
  output logic [CNT_W-1:0]      issue_count,
  output logic [CNT_W-1:0]      stall_count
);

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [4:0]  dest;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        ill;
  } ex_t;

  ex_t         dec, ex_q;
  logic        ex_valid_q;
  logic        load;
  logic [5:0]  f_op, f_fn;
  logic [4:0]  f_rt, f_rd;
  logic [31:0] se, ze;

  assign f_op = bus.id_instr[31:26];
  assign f_rt = bus.id_instr[20:16];
  assign f_rd = bus.id_instr[15:11];
  assign f_fn = bus.id_instr[5:0];
  assign se   = {{16{bus.id_instr[15]}}, bus.id_instr[15:0]};
  assign ze   = {16'h0000, bus.id_instr[15:0]};

  // Decode. Operands default to the register values so illegal/NOP words
  // still carry something sane; illegal encodings get dest 0 and no effects.
  always_comb begin
    dec    = '0;
    dec.a  = bus.id_rs_data;
    dec.b  = bus.id_rt_data;
    dec.sd = bus.id_rt_data;
    if (bus.id_instr != 32'h0) begin
      unique case (f_op)
        6'h00: begin
          dec.dest = f_rd;
          dec.rw   = 1'b1;
          case (f_fn)
            6'h20, 6'h21: dec.op = 3'b010;
            6'h22, 6'h23: dec.op = 3'b110;
            6'h24:        dec.op = 3'b000;
            6'h25:        dec.op = 3'b001;
            6'h2A:        dec.op = 3'b111;
            default: begin
              dec.ill  = 1'b1;
              dec.rw   = 1'b0;
              dec.dest = '0;
            end
          endcase
        end
        6'h08, 6'h09: begin dec.op = 3'b010; dec.b = se; dec.dest = f_rt; dec.rw = 1'b1; end
        6'h0A:        begin dec.op = 3'b111; dec.b = se; dec.dest = f_rt; dec.rw = 1'b1; end
        6'h0C:        begin dec.op = 3'b000; dec.b = ze; dec.dest = f_rt; dec.rw = 1'b1; end
        6'h0D:        begin dec.op = 3'b001; dec.b = ze; dec.dest = f_rt; dec.rw = 1'b1; end
        // lui: ALU does the shift, stage only passes the raw immediate
        6'h0F:        begin dec.op = 3'b011; dec.b = ze; dec.dest = f_rt; dec.rw = 1'b1; end
        6'h23: begin dec.op = 3'b010; dec.b = se; dec.dest = f_rt; dec.rw = 1'b1; dec.mr = 1'b1; end
        6'h2B: begin dec.op = 3'b010; dec.b = se; dec.dest = f_rt; dec.mw = 1'b1; end
        6'h04: begin dec.op = 3'b110; dec.dest = f_rt; dec.br = 1'b1; end
        default: dec.ill = 1'b1;
      endcase
    end
    // $0 is hardwired; never request a write to it
    if (dec.dest == 5'd0) dec.rw = 1'b0;
  end

  assign bus.id_ready = !ex_valid_q || bus.ex_ready;
  assign load         = bus.id_valid && bus.id_ready && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q        <= '0;
      ex_valid_q  <= 1'b0;
      issue_count <= '0;
      stall_count <= '0;
    end else begin
      if (load) ex_q <= dec;
      if (flush)             ex_valid_q <= 1'b0;
      else if (load)         ex_valid_q <= 1'b1;
      else if (bus.ex_ready) ex_valid_q <= 1'b0;
      if (load) issue_count <= issue_count + 1'b1;
      if (ex_valid_q && !bus.ex_ready && !flush) stall_count <= stall_count + 1'b1;
    end
  end

  assign bus.ex_valid      = ex_valid_q;
  assign bus.ex_alu_op     = ex_q.op;
  assign bus.ex_alu_a      = ex_q.a;
  assign bus.ex_alu_b      = ex_q.b;
  assign bus.ex_store_data = ex_q.sd;
  assign bus.ex_dest       = ex_q.dest;
  assign bus.ex_reg_write  = ex_q.rw;
  assign bus.ex_mem_read   = ex_q.mr;
  assign bus.ex_mem_write  = ex_q.mw;
  assign bus.ex_branch     = ex_q.br;
  assign bus.ex_illegal    = ex_q.ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;
  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic [31:0] issue_count, stall_count;
  logic [3:0]  issue4, stall4;

  alu_issue_stage_if bif();
  alu_issue_stage_if if4();

  alu_issue_stage #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bif),
    .issue_count(issue_count), .stall_count(stall_count)
  );

  // narrow-counter copy sees identical stimulus; used for wrap behaviour
  assign if4.id_valid   = bif.id_valid;
  assign if4.id_instr   = bif.id_instr;
  assign if4.id_rs_data = bif.id_rs_data;
  assign if4.id_rt_data = bif.id_rt_data;
  assign if4.ex_ready   = bif.ex_ready;

  alu_issue_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .flush(flush), .bus(if4),
    .issue_count(issue4), .stall_count(stall4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, sd;
    logic [4:0]  dest;
    logic        rw, mr, mw, br, ill;
  } mf_t;

  function automatic mf_t mdec(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
    mf_t f;
    string m;
    int o, fn;
    logic [31:0] se, ze;
    o  = int'(i[31:26]);
    fn = int'(i[5:0]);
    se = {{16{i[15]}}, i[15:0]};
    ze = {16'h0, i[15:0]};
    m = "ill";
    if (i == 32'h0) m = "nop";
    else if (o == 0) begin
      case (fn)
        32, 33: m = "add";
        34, 35: m = "sub";
        36:     m = "and";
        37:     m = "or";
        42:     m = "slt";
        default: m = "ill";
      endcase
    end else begin
      case (o)
        8, 9: m = "addi";
        10:   m = "slti";
        12:   m = "andi";
        13:   m = "ori";
        15:   m = "lui";
        35:   m = "lw";
        43:   m = "sw";
        4:    m = "beq";
        default: m = "ill";
      endcase
    end
    f.op = 3'b000; f.a = rs; f.b = rt; f.sd = rt; f.dest = 5'd0;
    f.rw = 0; f.mr = 0; f.mw = 0; f.br = 0; f.ill = 0;
    case (m)
      "add": begin f.op = 3'b010; f.dest = i[15:11]; f.rw = 1; end
      "sub": begin f.op = 3'b110; f.dest = i[15:11]; f.rw = 1; end
      "and": begin f.op = 3'b000; f.dest = i[15:11]; f.rw = 1; end
      "or":  begin f.op = 3'b001; f.dest = i[15:11]; f.rw = 1; end
      "slt": begin f.op = 3'b111; f.dest = i[15:11]; f.rw = 1; end
      "addi": begin f.op = 3'b010; f.b = se; f.dest = i[20:16]; f.rw = 1; end
      "slti": begin f.op = 3'b111; f.b = se; f.dest = i[20:16]; f.rw = 1; end
      "andi": begin f.op = 3'b000; f.b = ze; f.dest = i[20:16]; f.rw = 1; end
      "ori":  begin f.op = 3'b001; f.b = ze; f.dest = i[20:16]; f.rw = 1; end
      "lui":  begin f.op = 3'b011; f.b = ze; f.dest = i[20:16]; f.rw = 1; end
      "lw":   begin f.op = 3'b010; f.b = se; f.dest = i[20:16]; f.rw = 1; f.mr = 1; end
      "sw":   begin f.op = 3'b010; f.b = se; f.dest = i[20:16]; f.mw = 1; end
      "beq":  begin f.op = 3'b110; f.dest = i[20:16]; f.br = 1; end
      "ill":  f.ill = 1;
      default: ;
    endcase
    if (f.dest == 5'd0) f.rw = 0;
    return f;
  endfunction

  mf_t m_f;
  bit  m_valid;
  int  m_issue, m_stall;

  always @(posedge clk or posedge reset) begin
    bit ld;
    if (reset) begin
      m_f = mdec(32'h0, 32'h0, 32'h0);
      m_f.a = 0; m_f.b = 0; m_f.sd = 0;
      m_valid = 0; m_issue = 0; m_stall = 0;
    end else begin
      ld = bif.id_valid && (!m_valid || bif.ex_ready) && !flush;
      if (m_valid && !bif.ex_ready && !flush) m_stall++;
      if (ld) begin
        m_f = mdec(bif.id_instr, bif.id_rs_data, bif.id_rt_data);
        m_issue++;
      end
      if (flush)             m_valid = 0;
      else if (ld)           m_valid = 1;
      else if (bif.ex_ready) m_valid = 0;
    end
  end

  // compare every cycle, away from the active edge
  always @(negedge clk) begin
    chk("ex_valid",    32'(bif.ex_valid), 32'(m_valid));
    chk("id_ready",    32'(bif.id_ready), 32'(!m_valid || bif.ex_ready));
    chk("alu_op",      32'(bif.ex_alu_op), 32'(m_f.op));
    chk("alu_a",       bif.ex_alu_a, m_f.a);
    chk("alu_b",       bif.ex_alu_b, m_f.b);
    chk("store_data",  bif.ex_store_data, m_f.sd);
    chk("dest",        32'(bif.ex_dest), 32'(m_f.dest));
    chk("ctrl",        32'({bif.ex_reg_write, bif.ex_mem_read, bif.ex_mem_write, bif.ex_branch, bif.ex_illegal}),
                       32'({m_f.rw, m_f.mr, m_f.mw, m_f.br, m_f.ill}));
    chk("issue_count", issue_count, 32'(m_issue));
    chk("stall_count", stall_count, 32'(m_stall));
    chk("issue4",      32'(issue4), 32'(m_issue % 16));
    chk("stall4",      32'(stall4), 32'(m_stall % 16));
  end

  // ---------------- stimulus ----------------
  // Inputs change 1 time unit after a rising edge; step() returns at the
  // same phase of the next cycle, so the edge it covered is visible.
  task automatic step(input bit v, input logic [31:0] instr, input logic [31:0] rs,
                      input logic [31:0] rt, input bit rdy, input bit fl);
    bif.id_valid = v; bif.id_instr = instr; bif.id_rs_data = rs; bif.id_rt_data = rt;
    bif.ex_ready = rdy; flush = fl;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bif.id_valid = 0; bif.id_instr = 0; bif.id_rs_data = 0; bif.id_rt_data = 0;
    bif.ex_ready = 1; flush = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_valid", 32'(bif.ex_valid), 32'd0);
    chk("rst_ready", 32'(bif.id_ready), 32'd1);
    chk("rst_a",     bif.ex_alu_a, 32'd0);

    // add $3,$1,$2
    step(1, 32'h00221820, 32'd11, 32'd7, 1, 0);
    chk("add_op",   32'(bif.ex_alu_op), 32'b010);
    chk("add_a",    bif.ex_alu_a, 32'd11);
    chk("add_b",    bif.ex_alu_b, 32'd7);
    chk("add_dest", 32'(bif.ex_dest), 32'd3);
    chk("add_rw",   32'(bif.ex_reg_write), 32'd1);
    chk("add_cnt",  issue_count, 32'd1);

    step(1, 32'h2005FFFF, 32'd1, 32'd2, 1, 0);
    chk("addi_b",    bif.ex_alu_b, 32'hFFFFFFFF);
    chk("addi_dest", 32'(bif.ex_dest), 32'd5);
    step(1, 32'h3405FFFF, 32'd1, 32'd2, 1, 0);
    chk("ori_b",  bif.ex_alu_b, 32'h0000FFFF);
    chk("ori_op", 32'(bif.ex_alu_op), 32'b001);
    step(1, 32'h3C041234, 32'd1, 32'd2, 1, 0);
    chk("lui_op", 32'(bif.ex_alu_op), 32'b011);
    chk("lui_b",  bif.ex_alu_b, 32'h00001234);
    step(1, 32'h8C220004, 32'd100, 32'd55, 1, 0);
    chk("lw_mr", 32'(bif.ex_mem_read), 32'd1);
    chk("lw_b",  bif.ex_alu_b, 32'd4);
    step(1, 32'hAC220004, 32'd100, 32'hDEADBEEF, 1, 0);
    chk("sw_mw", 32'(bif.ex_mem_write), 32'd1);
    chk("sw_rw", 32'(bif.ex_reg_write), 32'd0);
    chk("sw_sd", bif.ex_store_data, 32'hDEADBEEF);
    step(1, 32'h10220003, 32'd9, 32'd9, 1, 0);
    chk("beq_op", 32'(bif.ex_alu_op), 32'b110);
    chk("beq_br", 32'(bif.ex_branch), 32'd1);
    step(1, 32'h00220020, 32'd3, 32'd4, 1, 0);
    chk("r0_rw", 32'(bif.ex_reg_write), 32'd0);
    step(1, 32'hFC000000, 32'd3, 32'd4, 1, 0);
    chk("ill", 32'(bif.ex_illegal), 32'd1);
    step(1, 32'h00000000, 32'd3, 32'd4, 1, 0);
    chk("nop_ill", 32'(bif.ex_illegal), 32'd0);
    step(1, 32'h00A62022, 32'd20, 32'd5, 1, 0);   // sub $4,$5,$6
    step(1, 32'h00A6202A, 32'd20, 32'd5, 1, 0);   // slt
    step(1, 32'h00A62024, 32'd20, 32'd5, 1, 0);   // and
    step(1, 32'h30A7F0F0, 32'd20, 32'd5, 1, 0);   // andi
    step(1, 32'h28A7FFFE, 32'd20, 32'd5, 1, 0);   // slti
    step(0, 32'h0, 32'd0, 32'd0, 1, 0);           // consume, fields hold
    chk("drain_valid", 32'(bif.ex_valid), 32'd0);

    // stall: A loads, B waits 3 cycles, then loads with no bubble
    do_reset();
    step(1, 32'h00221820, 32'hA, 32'd1, 1, 0);
    repeat (3) step(1, 32'h00432020, 32'hB, 32'd2, 0, 0);
    chk("stall_cnt",   stall_count, 32'd3);
    chk("stall_rdy",   32'(bif.id_ready), 32'd0);
    chk("stall_hold",  bif.ex_alu_a, 32'hA);
    step(1, 32'h00432020, 32'hB, 32'd2, 1, 0);
    chk("unstall_a",   bif.ex_alu_a, 32'hB);
    chk("unstall_v",   32'(bif.ex_valid), 32'd1);
    chk("unstall_cnt", issue_count, 32'd2);

    // flush with valid contents and a waiting instruction
    step(1, 32'h00221820, 32'd1, 32'd2, 1, 1);
    chk("flush_valid", 32'(bif.ex_valid), 32'd0);
    chk("flush_cnt",   issue_count, 32'd2);

    // async reset in the middle of a stall
    step(1, 32'h00221820, 32'd5, 32'd6, 1, 0);
    step(1, 32'h00221820, 32'd7, 32'd8, 0, 0);
    #3 reset = 1'b1;
    #1;
    chk("areset_valid", 32'(bif.ex_valid), 32'd0);
    chk("areset_a",     bif.ex_alu_a, 32'd0);
    chk("areset_ctrl",  32'({bif.ex_alu_op, bif.ex_dest, bif.ex_reg_write}), 32'd0);
    chk("areset_cnt",   issue_count | stall_count, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // 16 back-to-back issues wrap the 4-bit counter
    do_reset();
    for (int k = 0; k < 16; k++) step(1, 32'h00221820, 32'(k), 32'(k + 1), 1, 0);
    chk("wrap4",   32'(issue4), 32'd0);
    chk("wrap32",  issue_count, 32'd16);
    step(0, 32'h0, 32'd0, 32'd0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
